// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register sequencer: widths, op encodings,
// FSM states and the op-to-strobe decode.
package reg_seq_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;
  localparam int ERR_W  = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic cl;
    logic ld;
    logic inc;
    logic dec;
    logic sr;
    logic sl;
  } strobe_t;

  // NOP and the reserved code decode to no strobe at all.
  function automatic strobe_t op_strobe(op_e op);
    strobe_t s;
    s = '0;
    case (op)
      OP_CLR:  s.cl  = 1'b1;
      OP_LOAD: s.ld  = 1'b1;
      OP_INC:  s.inc = 1'b1;
      OP_DEC:  s.dec = 1'b1;
      OP_SHR:  s.sr  = 1'b1;
      OP_SHL:  s.sl  = 1'b1;
      default: s     = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_model.sv
// Combinational next-value model of the driven 4-bit register for one
// strobe of the given op; sin_i is the serial-in bit used by the shifts.
module reg_model
  import reg_seq_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sin_i,
  output logic [DATA_W-1:0] next_o
);

  always_comb begin
    next_o = exp_i;
    case (op_e'(op_i))
      OP_CLR:  next_o = '0;
      OP_LOAD: next_o = data_i;
      OP_INC:  next_o = exp_i + DATA_W'(1);
      OP_DEC:  next_o = exp_i - DATA_W'(1);
      OP_SHR:  next_o = {sin_i, exp_i[DATA_W-1:1]};
      OP_SHL:  next_o = {exp_i[DATA_W-2:0], sin_i};
      default: next_o = exp_i;
    endcase
  end

endmodule

// File: rtl/reg_seq.sv
// Command sequencer that drives control strobes of an external 4-bit
// register, tracks its expected value and checks the read-back.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_* are
// don't-care at every other edge.
module reg_seq
  import reg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic [DATA_W-1:0] reg_out,
  output logic              cl,
  output logic              ld,
  output logic              inc,
  output logic              dec,
  output logic              sr,
  output logic              sl,
  output logic [DATA_W-1:0] in,
  output logic              ir,
  output logic              il,
  output logic              busy,
  output logic [DATA_W-1:0] exp_out,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        dbg_state
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  strobe_t            strb_q, strb_d;
  logic [DATA_W-1:0]  in_q, in_d;
  logic               ir_q, ir_d;
  logic               il_q, il_d;
  logic [DATA_W-1:0]  exp_q, exp_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic               mis_q, mis_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               issue_en;
  op_e                issue_op;
  logic [DATA_W-1:0]  issue_data;
  logic [DATA_W-1:0]  model_next;

  reg_model u_model (
    .op_i   (op_q),
    .exp_i  (exp_q),
    .data_i (data_q),
    .sin_i  (data_q[0]),
    .next_o (model_next)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    cmp_valid_d = (state_q == ST_ISSUE);
    mis_d       = mis_q;
    err_d       = err_q;
    issue_en    = 1'b0;
    issue_op    = op_q;
    issue_data  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = op_e'(cmd_op);
          data_d     = cmd_data;
          cnt_d      = (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;
          state_d    = ST_ISSUE;
          issue_en   = 1'b1;
          issue_op   = op_e'(cmd_op);
          issue_data = cmd_data;
        end
      end
      ST_ISSUE: begin
        // The register samples this cycle's strobe on the same edge.
        exp_d = model_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          issue_en = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Strobes are decoded one cycle ahead so they leave flops directly.
    strb_d = '0;
    in_d   = '0;
    ir_d   = 1'b0;
    il_d   = 1'b0;
    if (issue_en) begin
      strb_d = op_strobe(issue_op);
      in_d   = (issue_op == OP_LOAD) ? issue_data : '0;
      ir_d   = (issue_op == OP_SHR) && issue_data[0];
      il_d   = (issue_op == OP_SHL) && issue_data[0];
    end

    if (cmp_valid_q && (reg_out != exp_q)) begin
      mis_d = 1'b1;
      if (err_q != '1) err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      data_q      <= '0;
      cnt_q       <= '0;
      strb_q      <= '0;
      in_q        <= '0;
      ir_q        <= 1'b0;
      il_q        <= 1'b0;
      exp_q       <= '0;
      cmp_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      strb_q      <= strb_d;
      in_q        <= in_d;
      ir_q        <= ir_d;
      il_q        <= il_d;
      exp_q       <= exp_d;
      cmp_valid_q <= cmp_valid_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign cl        = strb_q.cl;
  assign ld        = strb_q.ld;
  assign inc       = strb_q.inc;
  assign dec       = strb_q.dec;
  assign sr        = strb_q.sr;
  assign sl        = strb_q.sl;
  assign in        = in_q;
  assign ir        = ir_q;
  assign il        = il_q;
  assign exp_out   = exp_q;
  assign mismatch  = mis_q;
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_seq.sv
// Bench for reg_seq: a behavioural 4-bit register answers the strobes and a
// command-level reference model predicts every cycle of each command.
module tb_reg_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_cnt;
  logic [3:0] reg_out;
  logic       cl, ld, inc, dec, sr, sl;
  logic [3:0] in;
  logic       ir, il;
  logic       busy;
  logic [3:0] exp_out;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;

  logic [3:0] tb_reg;
  logic       force_zero;

  int n_vec;
  int n_err;

  // model state
  int m_exp;
  int m_err;
  bit m_mis;

  reg_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .reg_out   (reg_out),
    .cl        (cl),
    .ld        (ld),
    .inc       (inc),
    .dec       (dec),
    .sr        (sr),
    .sl        (sl),
    .in        (in),
    .ir        (ir),
    .il        (il),
    .busy      (busy),
    .exp_out   (exp_out),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external register driven by the strobes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_reg <= 4'd0;
    else if (cl)  tb_reg <= 4'd0;
    else if (ld)  tb_reg <= in;
    else if (inc) tb_reg <= tb_reg + 4'd1;
    else if (dec) tb_reg <= tb_reg - 4'd1;
    else if (sr)  tb_reg <= {ir, tb_reg[3:1]};
    else if (sl)  tb_reg <= {tb_reg[2:0], il};
  end
  assign reg_out = force_zero ? 4'd0 : tb_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int nxt(input int op, input int v, input int d);
    case (op)
      1: return 0;
      2: return d;
      3: return (v + 1) % 16;
      4: return (v + 15) % 16;
      5: return (v / 2) + 8 * (d % 2);
      6: return ((v * 2) % 16) + (d % 2);
      default: return v;
    endcase
  endfunction

  // {cl, ld, inc, dec, sr, sl}
  function automatic logic [5:0] strb_of(input int op);
    if (op >= 1 && op <= 6) return 6'b100000 >> (op - 1);
    return 6'b000000;
  endfunction

  function automatic void model_reset();
    m_exp = 0;
    m_err = 0;
    m_mis = 0;
  endfunction

  // Called at a negedge while IDLE; returns at the negedge of the first
  // IDLE cycle after the command.
  task automatic run_cmd(input int op, input int data, input int cnt, input bit frc);
    int n;
    n = (cnt == 0) ? 1 : cnt;
    check("ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op[2:0];
    cmd_data   = data[3:0];
    cmd_cnt    = cnt[3:0];
    force_zero = frc;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      check("busy_issue", busy, 1);
      check("ready_issue", cmd_ready, 0);
      check("strobe", {cl, ld, inc, dec, sr, sl}, strb_of(op));
      check("in", in, (op == 2) ? data : 0);
      check("ir", ir, (op == 5) ? data % 2 : 0);
      check("il", il, (op == 6) ? data % 2 : 0);
      check("exp_issue", exp_out, m_exp);
      m_exp = nxt(op, m_exp, data);
      if ((frc ? 0 : m_exp) != m_exp) begin
        m_mis = 1;
        if (m_err < 255) m_err++;
      end
      // junk on the command bus must be ignored while busy
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_data  = 4'($urandom_range(0, 15));
      cmd_cnt   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    check("busy_drain", busy, 1);
    check("strobe_drain", {cl, ld, inc, dec, sr, sl}, 0);
    check("exp_drain", exp_out, m_exp);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("ready_after", cmd_ready, 1);
    check("busy_after", busy, 0);
    check("exp_after", exp_out, m_exp);
    check("mismatch", mismatch, m_mis);
    check("err_cnt", err_cnt, m_err);
    force_zero = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_data   = 4'd0;
    cmd_cnt    = 4'd0;
    force_zero = 1'b0;
    model_reset();
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_exp", exp_out, 0);
    check("rst_mis", mismatch, 0);
    check("rst_err", err_cnt, 0);
    check("rst_strobe", {cl, ld, inc, dec, sr, sl, in, ir, il}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed sequences
    run_cmd(2, 4'b1010, 0, 0);
    run_cmd(2, 4'b1110, 0, 0);
    run_cmd(3, 0, 3, 0);
    run_cmd(1, 0, 0, 0);
    run_cmd(4, 0, 1, 0);
    run_cmd(2, 4'b1001, 1, 0);
    run_cmd(5, 1, 2, 0);
    run_cmd(6, 0, 1, 0);
    run_cmd(0, 0, 2, 0);
    run_cmd(7, 5, 1, 0);

    // randomized commands
    for (int i = 0; i < 40; i++)
      run_cmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 6), 0);

    // forced read-back failures, then saturation
    run_cmd(2, 4'b0101, 0, 1);
    run_cmd(2, 4'b0101, 0, 0);
    for (int i = 0; i < 20; i++) run_cmd(2, 4'b0101, 15, 1);

    // reset in the middle of a multi-cycle INC
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_data  = 4'd0;
    cmd_cnt   = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_strobe", {cl, ld, inc, dec, sr, sl, in, ir, il}, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", cmd_ready, 1);
    check("mid_exp", exp_out, 0);
    check("mid_mis", mismatch, 0);
    check("mid_err", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(2, 4'b0110, 0, 0);
    for (int i = 0; i < 10; i++)
      run_cmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
